// File: rtl/ysyx_25020037_ifu_pkg.sv
// Shared core/SoC configuration: AXI response codes and the boot address.
// Imported by the IFU and by the SoC top, so both agree on the reset PC.
// Holds constants only; no logic lives here.
package ysyx_25020037_ifu_pkg;

  // AXI read response code for a successful access
  localparam logic [1:0]  RESP_OKAY        = 2'b00;

  // First fetch address after reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch unit: holds the PC, reads one instruction over AXI4-Lite, hands it to decode.
// Latency: arvalid one cycle after wb_valid; data two cycles later with a zero-wait slave.
// Backpressure: arvalid/rready wait for the slave; ifu_valid holds until idu_ready; next fetch waits for wb_valid.
module ysyx_25020037_ifu
  import ysyx_25020037_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        ifu_valid,
  input  logic        idu_ready,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        fetch_err,
  input  logic        wb_valid,
  input  logic [31:0] wb_npc
);

  // LAUNCH is only reachable from reset; the steady-state loop is AR -> R -> HOLD -> WB.
  typedef enum logic [2:0] {
    S_LAUNCH = 3'd0,
    S_AR     = 3'd1,
    S_R      = 3'd2,
    S_HOLD   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] inst_q, inst_n;
  logic        arvalid_q, arvalid_n;
  logic        rready_q, rready_n;
  logic        ifu_valid_q, ifu_valid_n;
  logic        err_q, err_n;

  // araddr and pc are the same register: the address stays stable until the next redirect.
  assign araddr    = pc_q;
  assign pc        = pc_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign ifu_valid = ifu_valid_q;
  assign inst      = inst_q;
  assign fetch_err = err_q;

  // Next-state and next-output logic; every register holds its value unless a handshake fires.
  always_comb begin
    state_n     = state_q;
    pc_n        = pc_q;
    inst_n      = inst_q;
    arvalid_n   = arvalid_q;
    rready_n    = rready_q;
    ifu_valid_n = ifu_valid_q;
    err_n       = err_q;
    case (state_q)
      S_LAUNCH: begin
        arvalid_n = 1'b1;
        state_n   = S_AR;
      end
      S_AR: begin
        if (arvalid_q && arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = S_R;
        end
      end
      S_R: begin
        if (rvalid && rready_q) begin
          inst_n      = rdata;
          rready_n    = 1'b0;
          ifu_valid_n = 1'b1;
          // A misaligned-PC flag from the redirect survives an OKAY response.
          err_n       = err_q | (rresp != RESP_OKAY);
          state_n     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ifu_valid_q && idu_ready) begin
          ifu_valid_n = 1'b0;
          state_n     = S_WB;
        end
      end
      S_WB: begin
        // pc stays put until write-back answers, since decode still reads it.
        if (wb_valid) begin
          pc_n      = {wb_npc[31:2], 2'b00};
          err_n     = (wb_npc[1:0] != 2'b00);
          arvalid_n = 1'b1;
          state_n   = S_AR;
        end
      end
      default: begin
        state_n = S_LAUNCH;
      end
    endcase
  end

  // State and output registers with asynchronous reset to the boot state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LAUNCH;
      pc_q        <= RESET_PC;
      inst_q      <= 32'h0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      ifu_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      pc_q        <= pc_n;
      inst_q      <= inst_n;
      arvalid_q   <= arvalid_n;
      rready_q    <= rready_n;
      ifu_valid_q <= ifu_valid_n;
      err_q       <= err_n;
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// Directed bench for the IFU with a small AXI4-Lite read slave that has programmable wait states.
// Outputs are sampled on the falling edge; stimulus also changes on the falling edge.
// Expected values are hand-computed constants and a fixed instruction table.
module tb_ysyx_25020037_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        ifu_valid;
  logic        idu_ready;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        fetch_err;
  logic        wb_valid;
  logic [31:0] wb_npc;

  int          errors = 0;
  int          checks = 0;

  // slave configuration
  int          ar_wait;
  int          r_wait;
  logic [1:0]  resp_cfg;

  always #5 clk = ~clk;

  ysyx_25020037_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready),
    .ifu_valid (ifu_valid),
    .idu_ready (idu_ready),
    .pc        (pc),
    .inst      (inst),
    .fetch_err (fetch_err),
    .wb_valid  (wb_valid),
    .wb_npc    (wb_npc)
  );

  // instruction memory contents
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h8000_0000: mem_rd = 32'h0000_0413;
      32'h8000_0004: mem_rd = 32'h0040_0193;
      32'h8000_0010: mem_rd = 32'h0010_0093;
      32'h8000_0014: mem_rd = 32'h0020_0113;
      default:       mem_rd = 32'hdead_beef;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // AXI4-Lite read slave: phase 0 address, 1 data, 2 data retire
  initial begin : slave
    int          phase;
    int          cnt;
    logic [31:0] lat_addr;
    phase    = 0;
    cnt      = 0;
    lat_addr = 32'h0;
    arready  = 1'b0;
    rvalid   = 1'b0;
    rdata    = 32'h0;
    rresp    = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase   = 0;
        cnt     = 0;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = 32'h0;
        rresp   = 2'b00;
      end else begin
        case (phase)
          0: begin
            if (arvalid) begin
              if (cnt < ar_wait) begin
                cnt++;
                arready = 1'b0;
              end else begin
                arready  = 1'b1;
                lat_addr = araddr;
                cnt      = 0;
                phase    = 1;
              end
            end
          end
          1: begin
            arready = 1'b0;
            if (rready) begin
              if (cnt < r_wait) begin
                cnt++;
              end else begin
                rvalid = 1'b1;
                rdata  = mem_rd(lat_addr);
                rresp  = resp_cfg;
                cnt    = 0;
                phase  = 2;
              end
            end
          end
          default: begin
            rvalid = 1'b0;
            rdata  = 32'h0;
            rresp  = 2'b00;
            phase  = 0;
          end
        endcase
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},        pc,        32'h8000_0000);
    chk({tag, "_araddr"},    araddr,    32'h8000_0000);
    chk({tag, "_arvalid"},   arvalid,   32'h0);
    chk({tag, "_rready"},    rready,    32'h0);
    chk({tag, "_ifu_valid"}, ifu_valid, 32'h0);
    chk({tag, "_fetch_err"}, fetch_err, 32'h0);
    chk({tag, "_inst"},      inst,      32'h0);
  endtask

  // Boot sequence from reset release (cycle 0) with a zero-wait slave.
  task automatic boot_fetch(input string tag);
    rst = 1'b0;
    chk({tag, "_c0_arvalid"}, arvalid, 32'h0);
    @(negedge clk);
    chk({tag, "_c1_arvalid"}, arvalid, 32'h1);
    chk({tag, "_c1_araddr"},  araddr,  32'h8000_0000);
    @(negedge clk);
    chk({tag, "_c2_rready"},    rready,    32'h1);
    chk({tag, "_c2_ifu_valid"}, ifu_valid, 32'h0);
    @(negedge clk);
    chk({tag, "_c3_ifu_valid"}, ifu_valid, 32'h1);
    chk({tag, "_c3_inst"},      inst,      32'h0000_0413);
    chk({tag, "_c3_pc"},        pc,        32'h8000_0000);
    chk({tag, "_c3_fetch_err"}, fetch_err, 32'h0);
    chk({tag, "_c3_rready"},    rready,    32'h0);
  endtask

  // Decode accepts; an extra idu_ready cycle with ifu_valid low must be harmless.
  task automatic accept(input string tag, input logic [31:0] exp_pc);
    idu_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_drop"}, ifu_valid, 32'h0);
    @(negedge clk);
    idu_ready = 1'b0;
    chk({tag, "_wb_pc"},      pc,        exp_pc);
    chk({tag, "_wb_arvalid"}, arvalid,   32'h0);
    chk({tag, "_wb_valid"},   ifu_valid, 32'h0);
  endtask

  // Write-back redirect; lat counts falling edges after the wb_valid edge until ifu_valid.
  task automatic redirect(input string tag, input logic [31:0] npc, input int aw, input int rw,
                          input logic [1:0] rs, output int lat);
    logic [31:0] exp_addr;
    exp_addr = {npc[31:2], 2'b00};
    ar_wait  = aw;
    r_wait   = rw;
    resp_cfg = rs;
    wb_valid = 1'b1;
    wb_npc   = npc;
    @(negedge clk);
    wb_valid = 1'b0;
    chk({tag, "_arvalid"}, arvalid, 32'h1);
    chk({tag, "_araddr"},  araddr,  exp_addr);
    lat = 0;
    while (!ifu_valid && lat < 30) begin
      @(negedge clk);
      lat++;
      if (arvalid) chk({tag, "_araddr_stable"}, araddr, exp_addr);
    end
    chk({tag, "_ifu_valid"}, ifu_valid, 32'h1);
    chk({tag, "_pc"},        pc,        exp_addr);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation timeout");
  end

  initial begin : main
    int lat;
    rst       = 1'b1;
    idu_ready = 1'b0;
    wb_valid  = 1'b0;
    wb_npc    = 32'h0;
    ar_wait   = 0;
    r_wait    = 0;
    resp_cfg  = 2'b00;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");

    boot_fetch("boot");

    // HOLD with idu_ready low for five cycles, wb_valid pulsed mid-way must be ignored
    for (int i = 0; i < 5; i++) begin
      wb_valid = (i == 2);
      wb_npc   = 32'h8000_0100;
      @(negedge clk);
      chk("hold_valid",   ifu_valid, 32'h1);
      chk("hold_inst",    inst,      32'h0000_0413);
      chk("hold_pc",      pc,        32'h8000_0000);
      chk("hold_arvalid", arvalid,   32'h0);
    end
    wb_valid = 1'b0;
    accept("acc0", 32'h8000_0000);

    // zero-wait redirect baseline
    redirect("zw", 32'h8000_0014, 0, 0, 2'b00, lat);
    chk("zw_lat",  lat,       32'd2);
    chk("zw_inst", inst,      32'h0020_0113);
    chk("zw_err",  fetch_err, 32'h0);
    accept("acc1", 32'h8000_0014);

    // 2 arready and 3 rvalid wait cycles add exactly 5 cycles
    redirect("ws", 32'h8000_0010, 2, 3, 2'b00, lat);
    chk("ws_lat",  lat,       32'd7);
    chk("ws_inst", inst,      32'h0010_0093);
    chk("ws_err",  fetch_err, 32'h0);
    accept("acc2", 32'h8000_0010);

    // SLVERR response flags the instruction
    redirect("slverr", 32'h8000_0020, 0, 0, 2'b10, lat);
    chk("slverr_err",  fetch_err, 32'h1);
    chk("slverr_inst", inst,      32'hdead_beef);
    accept("acc3", 32'h8000_0020);

    // following OKAY fetch is clean again
    redirect("okay", 32'h8000_0024, 0, 0, 2'b00, lat);
    chk("okay_err", fetch_err, 32'h0);
    accept("acc4", 32'h8000_0024);

    // misaligned next PC: fetched aligned, delivered with fetch_err
    redirect("mis", 32'h8000_0006, 0, 0, 2'b00, lat);
    chk("mis_err",  fetch_err, 32'h1);
    chk("mis_inst", inst,      32'h0040_0193);
    chk("mis_lat",  lat,       32'd2);
    accept("acc5", 32'h8000_0004);

    // reset while waiting for read data
    ar_wait  = 0;
    r_wait   = 5;
    resp_cfg = 2'b00;
    wb_valid = 1'b1;
    wb_npc   = 32'h8000_0040;
    @(negedge clk);
    wb_valid = 1'b0;
    @(negedge clk);
    chk("midr_rready", rready, 32'h1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("midr");
    r_wait = 0;
    repeat (2) @(negedge clk);
    boot_fetch("reboot");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
